// File: rtl/phase_timer_pkg.sv
// Shared types and constants for the phase timer: FSM state encoding,
// prescaler width and cycles-per-second tables (real clock and fast-sim).
package phase_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  localparam int PRESCALE_W = 23;

  localparam logic [PRESCALE_W-1:0] CPS_REAL_1M = 23'd1_000_000;
  localparam logic [PRESCALE_W-1:0] CPS_REAL_2M = 23'd2_000_000;
  localparam logic [PRESCALE_W-1:0] CPS_REAL_4M = 23'd4_000_000;
  localparam logic [PRESCALE_W-1:0] CPS_REAL_8M = 23'd8_000_000;

  localparam logic [PRESCALE_W-1:0] CPS_FAST_1M = 23'd4;
  localparam logic [PRESCALE_W-1:0] CPS_FAST_2M = 23'd8;
  localparam logic [PRESCALE_W-1:0] CPS_FAST_4M = 23'd16;
  localparam logic [PRESCALE_W-1:0] CPS_FAST_8M = 23'd32;

  function automatic logic [PRESCALE_W-1:0] cps_real(input logic [1:0] code);
    case (code)
      2'd0:    cps_real = CPS_REAL_1M;
      2'd1:    cps_real = CPS_REAL_2M;
      2'd2:    cps_real = CPS_REAL_4M;
      default: cps_real = CPS_REAL_8M;
    endcase
  endfunction

  function automatic logic [PRESCALE_W-1:0] cps_fast(input logic [1:0] code);
    case (code)
      2'd0:    cps_fast = CPS_FAST_1M;
      2'd1:    cps_fast = CPS_FAST_2M;
      2'd2:    cps_fast = CPS_FAST_4M;
      default: cps_fast = CPS_FAST_8M;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer_sec_prescaler.sv
// One-second prescaler: latches the clock-frequency code on load and counts 0..N-1.
// PHASE_TIMER_FAST_SIM_EN selects the short simulation periods (4/8/16/32 cycles).
module sec_prescaler
  import phase_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [1:0] i_freq,
  input  logic       i_en,
  input  logic       i_clr,
  output logic       o_wrap
);

  logic [1:0]            r_code;
  logic [PRESCALE_W-1:0] r_count;
  logic [PRESCALE_W-1:0] w_tc;

  always_comb begin
`ifdef PHASE_TIMER_FAST_SIM_EN
    w_tc = cps_fast(r_code) - PRESCALE_W'(1);
`else
    w_tc = cps_real(r_code) - PRESCALE_W'(1);
`endif
  end

  assign o_wrap = i_en && (r_count == w_tc);

  // Clear outranks load so an abort never arms a new phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code  <= 2'd0;
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_code  <= i_freq;
      r_count <= '0;
    end else if (o_wrap) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/phase_timer.sv
// Phase timer: counts a programmed number of seconds with pause and abort.
// Build with PHASE_TIMER_FAST_SIM_EN for short simulation seconds.
module phase_timer
  import phase_timer_pkg::*;
#(
  parameter int DUR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       i_clk_freq,
  input  logic             i_start,
  input  logic [DUR_W-1:0] i_duration,
  input  logic             i_pause,
  input  logic             i_abort,
  output logic             o_busy,
  output logic [DUR_W-1:0] o_remaining,
  output logic             o_sec_tick,
  output logic             o_done
);

  state_t           r_state;
  logic [DUR_W-1:0] r_remaining;
  logic             r_sec_tick;
  logic             r_done;

  logic w_load;
  logic w_en;
  logic w_wrap;

  assign w_load = (r_state == ST_IDLE) && i_start && !i_abort;
  assign w_en   = (r_state == ST_RUN) && !i_abort;

  sec_prescaler u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_freq (i_clk_freq),
    .i_en   (w_en),
    .i_clr  (i_abort),
    .o_wrap (w_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_sec_tick  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_sec_tick <= 1'b0;
      r_done     <= 1'b0;
      if (i_abort) begin
        r_state     <= ST_IDLE;
        r_remaining <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_start) begin
              if (i_duration != '0) begin
                r_state     <= ST_RUN;
                r_remaining <= i_duration;
              end else begin
                r_done <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            // A wrap finishes its tick and decrement before any pause takes effect.
            if (w_wrap) begin
              r_sec_tick <= 1'b1;
              if (r_remaining <= DUR_W'(1)) begin
                r_remaining <= '0;
                r_done      <= 1'b1;
                r_state     <= ST_IDLE;
              end else begin
                r_remaining <= r_remaining - DUR_W'(1);
                if (i_pause) r_state <= ST_PAUSED;
              end
            end else if (i_pause) begin
              r_state <= ST_PAUSED;
            end
          end
          ST_PAUSED: begin
            if (!i_pause) r_state <= ST_RUN;
          end
          default: begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
          end
        endcase
      end
    end
  end

  assign o_busy      = (r_state != ST_IDLE);
  assign o_remaining = r_remaining;
  assign o_sec_tick  = r_sec_tick;
  assign o_done      = r_done;

endmodule

// File: tb/tb_phase_timer.sv
// Scoreboard bench for phase_timer; timing-heavy cases run when
// PHASE_TIMER_FAST_SIM_EN is defined, short cases run in every build.
module tb_phase_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] i_clk_freq;
  logic       i_start;
  logic [7:0] i_duration;
  logic       i_pause;
  logic       i_abort;
  logic       o_busy;
  logic [7:0] o_remaining;
  logic       o_sec_tick;
  logic       o_done;

  phase_timer #(.DUR_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clk_freq  (i_clk_freq),
    .i_start     (i_start),
    .i_duration  (i_duration),
    .i_pause     (i_pause),
    .i_abort     (i_abort),
    .o_busy      (o_busy),
    .o_remaining (o_remaining),
    .o_sec_tick  (o_sec_tick),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    logic       tick;
    logic       done;
    logic [7:0] rem;
    logic       busy;
  } ev_t;

  ev_t sb_q[$];
  ev_t mon_ev;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int c, input logic t, input logic d, input logic [7:0] r);
    ev_t e;
    e.cyc  = c;
    e.tick = t;
    e.done = d;
    e.rem  = r;
    e.busy = !d;
    sb_q.push_back(e);
  endtask

  // Monitor: every tick/done the DUT presents is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (o_sec_tick || o_done)) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event cycle=%0d tick=%0b done=%0b rem=%0d expected no event",
                 cyc, o_sec_tick, o_done, o_remaining);
      end else begin
        mon_ev = sb_q.pop_front();
        chk("ev_cycle", cyc, mon_ev.cyc);
        chk("ev_tick", int'(o_sec_tick), int'(mon_ev.tick));
        chk("ev_done", int'(o_done), int'(mon_ev.done));
        chk("ev_remaining", int'(o_remaining), int'(mon_ev.rem));
        chk("ev_busy", int'(o_busy), int'(mon_ev.busy));
        $display("event cycle=%0d tick=%0b done=%0b rem=%0d", cyc, o_sec_tick, o_done, o_remaining);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issues a one-cycle start; entry is the first cycle after start is sampled.
  task automatic do_start(input logic [1:0] f, input logic [7:0] d, output int entry);
    i_clk_freq = f;
    i_duration = d;
    i_start    = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    entry   = cyc;
    $display("start freq=%0d dur=%0d entry=%0d", f, d, entry);
  endtask

  int e;
  int e2;

  initial begin
    rst_n      = 1'b0;
    i_clk_freq = 2'd0;
    i_start    = 1'b0;
    i_duration = 8'd0;
    i_pause    = 1'b0;
    i_abort    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_remaining", int'(o_remaining), 0);
    chk("rst_tick", int'(o_sec_tick), 0);
    chk("rst_done", int'(o_done), 0);
    rst_n = 1'b1;
    goto(cyc + 2);

    // Zero duration: done one cycle after start, never busy.
    do_start(2'd0, 8'd0, e);
    push_ev(e, 1'b0, 1'b1, 8'd0);
    chk("dur0_busy", int'(o_busy), 0);
    goto(e + 1);
    chk("dur0_busy_after", int'(o_busy), 0);
    goto(e + 3);

    // Start together with abort in IDLE is dropped.
    i_abort = 1'b1;
    do_start(2'd0, 8'd4, e);
    i_abort = 1'b0;
    chk("start_abort_busy", int'(o_busy), 0);
    chk("start_abort_rem", int'(o_remaining), 0);
    i_abort = 1'b1;
    do_start(2'd0, 8'd0, e);
    i_abort = 1'b0;
    goto(e + 3);
    chk("start0_abort_busy", int'(o_busy), 0);

    // Reload ignored while busy, pause holds, abort clears.
    do_start(2'd3, 8'd9, e);
    chk("load_rem", int'(o_remaining), 9);
    chk("load_busy", int'(o_busy), 1);
    goto(e + 3);
    i_duration = 8'd2;
    i_start    = 1'b1;
    goto(e + 4);
    i_start = 1'b0;
    chk("reload_ignored_rem", int'(o_remaining), 9);
    goto(e + 5);
    i_pause = 1'b1;
    goto(e + 7);
    chk("paused_busy", int'(o_busy), 1);
    chk("paused_rem", int'(o_remaining), 9);
    goto(e + 8);
    i_pause = 1'b0;
    goto(e + 12);
    i_abort = 1'b1;
    goto(e + 13);
    i_abort = 1'b0;
    chk("abort_busy", int'(o_busy), 0);
    chk("abort_rem", int'(o_remaining), 0);
    goto(e + 50);

    // Asynchronous reset mid-phase discards it.
    do_start(2'd3, 8'd5, e);
    goto(e + 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(o_busy), 0);
    chk("midrst_rem", int'(o_remaining), 0);
    chk("midrst_tick", int'(o_sec_tick), 0);
    chk("midrst_done", int'(o_done), 0);
    goto(e + 6);
    rst_n = 1'b1;
    goto(e + 7);
    chk("postrst_busy", int'(o_busy), 0);
    chk("postrst_rem", int'(o_remaining), 0);
    goto(e + 45);

`ifdef PHASE_TIMER_FAST_SIM_EN
    // Three ticks at N=4, done with the last.
    do_start(2'd0, 8'd3, e);
    push_ev(e + 4, 1'b1, 1'b0, 8'd2);
    push_ev(e + 8, 1'b1, 1'b0, 8'd1);
    push_ev(e + 12, 1'b1, 1'b1, 8'd0);
    chk("t1_entry_busy", int'(o_busy), 1);
    chk("t1_entry_rem", int'(o_remaining), 3);
    goto(e + 12);
    chk("t1_done_busy", int'(o_busy), 0);
    goto(e + 14);

    // N=32 with a 10-cycle pause starting at RUN cycle 5.
    do_start(2'd3, 8'd1, e);
    push_ev(e + 42, 1'b1, 1'b1, 8'd0);
    goto(e + 5);
    i_pause = 1'b1;
    goto(e + 10);
    chk("t2_pause_busy", int'(o_busy), 1);
    chk("t2_pause_rem", int'(o_remaining), 1);
    goto(e + 15);
    i_pause = 1'b0;
    goto(e + 43);
    chk("t2_end_busy", int'(o_busy), 0);

    // Abort after two ticks at N=8, then a clean one-second phase.
    do_start(2'd1, 8'd5, e);
    push_ev(e + 8, 1'b1, 1'b0, 8'd4);
    push_ev(e + 16, 1'b1, 1'b0, 8'd3);
    goto(e + 18);
    i_abort = 1'b1;
    goto(e + 19);
    i_abort = 1'b0;
    chk("t4_abort_busy", int'(o_busy), 0);
    chk("t4_abort_rem", int'(o_remaining), 0);
    goto(e + 40);
    do_start(2'd1, 8'd1, e2);
    push_ev(e2 + 8, 1'b1, 1'b1, 8'd0);
    goto(e2 + 10);

    // Start while busy with duration 9 is ignored.
    do_start(2'd0, 8'd2, e);
    push_ev(e + 4, 1'b1, 1'b0, 8'd1);
    push_ev(e + 8, 1'b1, 1'b1, 8'd0);
    goto(e + 2);
    i_duration = 8'd9;
    i_start    = 1'b1;
    goto(e + 3);
    i_start = 1'b0;
    chk("t5_rem", int'(o_remaining), 2);
    goto(e + 10);
    chk("t5_end_busy", int'(o_busy), 0);

    // Frequency code change during RUN is ignored until the next start.
    do_start(2'd0, 8'd3, e);
    push_ev(e + 4, 1'b1, 1'b0, 8'd2);
    push_ev(e + 8, 1'b1, 1'b0, 8'd1);
    push_ev(e + 12, 1'b1, 1'b1, 8'd0);
    goto(e + 1);
    i_clk_freq = 2'd3;
    goto(e + 14);
    do_start(2'd3, 8'd1, e2);
    push_ev(e2 + 32, 1'b1, 1'b1, 8'd0);
    goto(e2 + 34);

    // Pause sampled on the wrap cycle: tick first, then one paused cycle.
    do_start(2'd0, 8'd2, e);
    push_ev(e + 4, 1'b1, 1'b0, 8'd1);
    push_ev(e + 9, 1'b1, 1'b1, 8'd0);
    goto(e + 3);
    i_pause = 1'b1;
    goto(e + 4);
    i_pause = 1'b0;
    chk("t7_paused_busy", int'(o_busy), 1);
    goto(e + 11);
`endif

    goto(cyc + 3);
    chk("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phase_timer.md
PHASE_TIMER -- requirements
Module: phase_timer

Interface
REQ-001 Parameter: DUR_W, default 8, width of duration and remaining-seconds fields.
REQ-002 clk  input  1  system clock; one clock domain only.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 clk_freq  input  2  clk frequency code: 00=1 MHz, 01=2 MHz, 10=4 MHz, 11=8 MHz.
REQ-005 start  input  1  single-cycle request; loads duration and begins a timed phase.
REQ-006 duration  input  DUR_W  phase length in seconds; sampled with start.
REQ-007 pause  input  1  level; holds the countdown while high.
REQ-008 abort  input  1  single-cycle request; terminates the phase without done.
REQ-009 busy  output  1  high in RUN or PAUSED.
REQ-010 remaining  output  DUR_W  seconds left in the current phase.
REQ-011 sec_tick  output  1  one-cycle pulse at each elapsed second while running.
REQ-012 done  output  1  one-cycle pulse at phase completion.

Function
REQ-013 FSM states IDLE, RUN, PAUSED, encoded as a 2-bit enum.
REQ-014 Cycles per second N = 1,000,000 x 2^clk_freq (1M/2M/4M/8M); prescaler is 23 bits and counts 0..N-1.
REQ-015 clk_freq is latched on accepted start; changes during RUN/PAUSED are ignored until the next start.
REQ-016 IDLE + start + duration!=0 -> RUN next cycle; remaining=duration and prescaler=0 visible that cycle.
REQ-017 IDLE + start + duration==0 -> done pulses the next cycle; state stays IDLE; sec_tick stays low.
REQ-018 RUN: prescaler increments each cycle; at N-1 it wraps to 0, sec_tick pulses and remaining decrements in the same cycle.
REQ-019 Decrement 1->0: done pulses with that sec_tick, busy drops, state -> IDLE next cycle; first done after exactly duration x N RUN cycles.
REQ-020 RUN + pause=1 -> PAUSED next cycle; prescaler and remaining frozen; no sec_tick in PAUSED.
REQ-021 PAUSED + pause=0 -> RUN next cycle; prescaler resumes from its held value.
REQ-022 start while busy is ignored (no reload, no restart).
REQ-023 abort has highest priority in any state: -> IDLE next cycle, remaining=0, prescaler=0, no done and no sec_tick in that cycle.
REQ-024 Simultaneous start and abort in IDLE: abort wins; start is dropped.
REQ-025 pause sampled in the same cycle as a prescaler wrap: the tick and decrement complete first, then PAUSED.
REQ-026 remaining never underflows; remaining wraps neither below 0 nor above duration.

Reset
REQ-027 rst_n low asynchronously forces IDLE, prescaler=0, latched clk_freq=00, remaining=0, busy=0, sec_tick=0, done=0.
REQ-028 Reset asserted mid-phase discards the phase; no done is emitted after release.
REQ-029 Operation resumes on the first rising clk edge after rst_n deasserts.

Configuration
REQ-030 Macro PHASE_TIMER_FAST_SIM_EN: when defined, N = 4 x 2^clk_freq (4/8/16/32 cycles); when undefined, N follows REQ-014.
REQ-031 All other behaviour is identical with and without the macro.

Structure
REQ-032 Package phase_timer_pkg holds the FSM state enum, the four cycles-per-second constants, both fast-sim and real, and the prescaler width (23).
REQ-033 Sub-module sec_prescaler holds the counter, terminal-count compare from the latched code, and the enable/clear inputs; it outputs a wrap pulse.
REQ-034 phase_timer holds the FSM, the remaining register, and output decode.

Verification (PHASE_TIMER_FAST_SIM_EN defined)
REQ-035 clk_freq=00, start with duration=3 -> sec_tick at cycles 4, 8, 12 after RUN entry; remaining 3->2->1->0; done coincides with the third tick.
REQ-036 clk_freq=11, duration=1, pause high for 10 cycles at RUN cycle 5 -> done at RUN-entry+42; no tick during pause.
REQ-037 duration=0 start -> done exactly one cycle later; busy never asserts.
REQ-038 clk_freq=01, duration=5, abort after 2 ticks -> IDLE, remaining=0, no done; a later start with duration=1 completes in 8 cycles.
REQ-039 start repeated while busy with duration=9 -> ignored; original duration completes; rst_n pulse mid-run -> all outputs zero, no done.
REQ-040 clk_freq changed from 00 to 11 during RUN -> tick spacing stays 4 cycles until the next start.
